clk_div_bank: RTL and testbench

- Parametrised, synthesizable successor to the fixed six-output PLL output stage.
- A bank of NUM_CH integer clock dividers, all driven from one input clock, each with programmable divide, high time and phase offset (in input cycles).
- Adds a lock sequencer and a valid/ready runtime reconfiguration port.
- Sits behind a PLL model or a board clock and provides derived clocks, or clock-enables, to downstream logic.

---
 rtl/pll_bank_pkg.sv | 39 +++
 rtl/clk_div_channel.sv | 60 ++++++
 rtl/clk_div_bank.sv | 150 +++++++++++++++
 tb/tb_clk_div_bank.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_bank_pkg.sv
// Shared types and helpers for the clock divider bank: FSM states, per-channel
// configuration record, start-value and request-validation functions.
package pll_bank_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_LOCK  = 2'd0,
    S_RUN   = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] divide;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } ch_cfg_t;

  // Counter value shown in the first run cycle; a phase of P delays the
  // rising edge by P input cycles.
  function automatic logic [CNT_W-1:0] start_value(input ch_cfg_t c);
    logic [CNT_W-1:0] v;
    if (c.phase == '0) begin
      v = '0;
    end else begin
      v = c.divide - c.phase;
    end
    return v;
  endfunction

  function automatic logic cfg_valid(input ch_cfg_t c, input logic ch_in_range);
    return ch_in_range
        && (c.divide >= CNT_W'(2))
        && (c.high >= CNT_W'(1))
        && (c.high < c.divide)
        && (c.phase < c.divide);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One integer divider channel: counts 0..DIVIDE-1 while running and drives a
// registered output that is high while the count is below HIGH.
module clk_div_channel
  import pll_bank_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  ch_cfg_t cfg,
  input  logic    hold,
  input  logic    run,
  output logic    clk_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cur_cnt;
  logic             held_q, held_d;
  logic             out_q, out_d;

  always_comb begin
    cnt_d   = cnt_q;
    held_d  = held_q;
    out_d   = out_q;
    cur_cnt = cnt_q;
    // The first run edge after a hold starts from the current config, so a
    // config written during the hold is picked up even for a one-cycle lock.
    if (held_q) begin
      cur_cnt = start_value(cfg);
    end else begin
      cur_cnt = cnt_q;
    end
    if (hold) begin
      held_d = 1'b1;
      out_d  = 1'b0;
    end else if (run) begin
      held_d = 1'b0;
      out_d  = (cur_cnt < cfg.high);
      if (cur_cnt == (cfg.divide - CNT_W'(1))) begin
        cnt_d = '0;
      end else begin
        cnt_d = cur_cnt + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      held_q <= 1'b1;
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= held_d;
      out_q  <= out_d;
    end
  end

  assign clk_out = out_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one input clock, with a
// lock sequencer and a valid/ready reconfiguration port.
module clk_div_bank #(
  parameter int  NUM_CH      = 6,
  parameter int  CNT_W       = 8,
  parameter int  LOCK_CYCLES = 16,
  parameter int  DEF_DIVIDE  = 4,
  parameter int  DEF_HIGH    = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLKIN1,
  input  logic              RST,
  input  logic              PWRDWN,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [CNT_W-1:0]  CFG_DIVIDE,
  input  logic [CNT_W-1:0]  CFG_HIGH,
  input  logic [CNT_W-1:0]  CFG_PHASE,
  output logic              CFG_ERR,
  output logic [NUM_CH-1:0] CLKOUT,
  output logic              LOCKED
);

  import pll_bank_pkg::*;

  localparam int             LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam ch_cfg_t        DEF_CFG   = '{divide: CNT_W'(DEF_DIVIDE),
                                           high:   CNT_W'(DEF_HIGH),
                                           phase:  '0};

  state_e          state_q, state_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            cfg_err_q, cfg_err_d;
  logic [CH_W-1:0] apply_ch_q, apply_ch_d;
  ch_cfg_t         apply_cfg_q, apply_cfg_d;
  ch_cfg_t         cfg_q [NUM_CH];
  ch_cfg_t         cfg_d [NUM_CH];

  ch_cfg_t         req_cfg;
  logic            ch_in_range;
  logic            req_ok;
  logic            accept;
  logic            run_en;

  always_comb begin
    req_cfg     = '{divide: CFG_DIVIDE, high: CFG_HIGH, phase: CFG_PHASE};
    ch_in_range = (32'(CFG_CH) < 32'(NUM_CH));
    req_ok      = cfg_valid(req_cfg, ch_in_range);
    accept      = CFG_VALID & cfg_ready_q;

    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    cfg_err_d   = 1'b0;
    apply_ch_d  = apply_ch_q;
    apply_cfg_d = apply_cfg_q;
    cfg_d       = cfg_q;

    // Power-down overrides any handshake and drops a pending apply.
    if (PWRDWN) begin
      state_d    = S_LOCK;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        S_LOCK: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d = S_RUN;
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end
        S_RUN: begin
          if (accept && req_ok) begin
            state_d     = S_APPLY;
            apply_ch_d  = CFG_CH;
            apply_cfg_d = req_cfg;
          end else if (accept) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        S_APPLY: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == apply_ch_q) begin
              cfg_d[i] = apply_cfg_q;
            end else begin
              cfg_d[i] = cfg_q[i];
            end
          end
          state_d    = S_LOCK;
          lock_cnt_d = '0;
        end
        default: begin
          state_d    = S_LOCK;
          lock_cnt_d = '0;
        end
      endcase
    end

    run_en      = (state_d == S_RUN);
    locked_d    = run_en;
    cfg_ready_d = run_en;
  end

  always_ff @(posedge CLKIN1) begin
    if (RST) begin
      state_q     <= S_LOCK;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      apply_ch_q  <= '0;
      apply_cfg_q <= DEF_CFG;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_q[i] <= DEF_CFG;
      end
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      apply_ch_q  <= apply_ch_d;
      apply_cfg_q <= apply_cfg_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel u_ch (
      .clk     (CLKIN1),
      .rst     (RST),
      .cfg     (cfg_q[g]),
      .hold    (~run_en),
      .run     (run_en),
      .clk_out (CLKOUT[g])
    );
  end

  assign LOCKED    = locked_q;
  assign CFG_READY = cfg_ready_q;
  assign CFG_ERR   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus randomized
// reconfiguration, compared every cycle against a cycle-count based model.
module tb_clk_div_bank;

  localparam int NUM_CH = 6;
  localparam int CNT_W  = 8;
  localparam int LC     = 16;
  localparam int DEF_D  = 4;
  localparam int DEF_H  = 2;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pwrdwn = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_divide = '0;
  logic [CNT_W-1:0]  cfg_high = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] clkout;
  logic              locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LC), .DEF_DIVIDE(DEF_D), .DEF_HIGH(DEF_H)
  ) dut (
    .CLKIN1(clk), .RST(rst), .PWRDWN(pwrdwn), .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready),
    .CFG_CH(cfg_ch), .CFG_DIVIDE(cfg_divide), .CFG_HIGH(cfg_high), .CFG_PHASE(cfg_phase),
    .CFG_ERR(cfg_err), .CLKOUT(clkout), .LOCKED(locked)
  );

  // Model: m_n counts edges since the last disruption; locked once m_n >= LC,
  // and channel i then shows ((DIV-PHASE) + (m_n-LC)) mod DIV < HIGH.
  int m_div [NUM_CH];
  int m_high[NUM_CH];
  int m_phase[NUM_CH];
  int m_n = 0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i]   <= DEF_D;
        m_high[i]  <= DEF_H;
        m_phase[i] <= 0;
      end
      m_n   <= 0;
      m_err <= 1'b0;
    end else if (pwrdwn) begin
      m_n   <= 0;
      m_err <= 1'b0;
    end else if (m_n >= LC && cfg_valid) begin
      if (int'(cfg_ch) < NUM_CH && cfg_divide >= 2 && cfg_high >= 1 &&
          cfg_high < cfg_divide && cfg_phase < cfg_divide) begin
        m_div[cfg_ch]   <= int'(cfg_divide);
        m_high[cfg_ch]  <= int'(cfg_high);
        m_phase[cfg_ch] <= int'(cfg_phase);
        m_n   <= -1;
        m_err <= 1'b0;
      end else begin
        m_n   <= m_n + 1;
        m_err <= 1'b1;
      end
    end else begin
      m_n   <= m_n + 1;
      m_err <= 1'b0;
    end
  end

  function automatic logic [NUM_CH+2:0] exp_vec();
    logic [NUM_CH-1:0] v;
    logic              l;
    v = '0;
    l = (m_n >= LC);
    if (l) begin
      for (int i = 0; i < NUM_CH; i++) begin
        v[i] = (((m_div[i] - m_phase[i] + (m_n - LC)) % m_div[i]) < m_high[i]);
      end
    end
    return {l, l, m_err, v};
  endfunction

  task automatic test_reset();
    int first_lock = 0;
    @(negedge clk);
    checks++;
    if ({locked, cfg_ready, cfg_err, clkout} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {locked, cfg_ready, cfg_err, clkout}, 9'b0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_model c=%0d got=%b exp=%b", c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
      end
      if (locked === 1'b1 && first_lock == 0) begin
        first_lock = c;
        checks++;
        if (clkout !== 6'b111111) begin
          errors++;
          $display("FAIL reset_first_clkout got=%b exp=%b", clkout, 6'b111111);
        end
      end
    end
    checks++;
    if (first_lock != LC) begin
      errors++;
      $display("FAIL reset_lock_cycle got=%0d exp=%0d", first_lock, LC);
    end
  endtask

  task automatic test_reconfig();
    int unl = 0;
    int r0 = -1;
    int r1 = -1;
    logic p0 = 1'b1;
    logic p1 = 1'b1;
    cfg_ch = 3'd1; cfg_divide = 8'd6; cfg_high = 8'd1; cfg_phase = 8'd2;
    cfg_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) cfg_valid = 1'b0;
      checks++;
      if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
        errors++;
        $display("FAIL reconfig_model c=%0d got=%b exp=%b", c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
      end
      if (locked === 1'b0) unl++;
      if (locked === 1'b1 && clkout[0] === 1'b1 && p0 === 1'b0 && r0 < 0) r0 = c;
      if (locked === 1'b1 && clkout[1] === 1'b1 && p1 === 1'b0 && r1 < 0) r1 = c;
      p0 = clkout[0];
      p1 = clkout[1];
    end
    checks++;
    if (unl != 17) begin
      errors++;
      $display("FAIL reconfig_unlocked_cycles got=%0d exp=%0d", unl, 17);
    end
    checks++;
    if (r0 < 0 || r1 - r0 != 2) begin
      errors++;
      $display("FAIL reconfig_phase_offset got=%0d exp=%0d", r1 - r0, 2);
    end
  endtask

  task automatic test_invalid();
    logic [CH_W-1:0]  t_ch [3] = '{3'd1, 3'd6, 3'd0};
    logic [CNT_W-1:0] t_dv [3] = '{8'd5, 8'd4, 8'd1};
    logic [CNT_W-1:0] t_hi [3] = '{8'd5, 8'd2, 8'd1};
    for (int k = 0; k < 3; k++) begin
      int errs = 0;
      cfg_ch = t_ch[k]; cfg_divide = t_dv[k]; cfg_high = t_hi[k]; cfg_phase = 8'd0;
      cfg_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c == 1) cfg_valid = 1'b0;
        checks++;
        if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
          errors++;
          $display("FAIL invalid_model k=%0d c=%0d got=%b exp=%b", k, c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
        end
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL invalid_locked k=%0d c=%0d got=%b exp=1", k, c, locked);
        end
        if (cfg_err === 1'b1) errs++;
      end
      checks++;
      if (errs != 1) begin
        errors++;
        $display("FAIL invalid_err_pulses k=%0d got=%0d exp=1", k, errs);
      end
    end
  endtask

  task automatic test_pwrdwn();
    int first_lock = 0;
    pwrdwn = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
        errors++;
        $display("FAIL pwrdwn_model c=%0d got=%b exp=%b", c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
      end
      if (c == 1) begin
        checks++;
        if ({locked, clkout} !== 7'b0) begin
          errors++;
          $display("FAIL pwrdwn_outputs got=%b exp=%b", {locked, clkout}, 7'b0);
        end
      end
    end
    pwrdwn = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
        errors++;
        $display("FAIL pwrdwn_relock_model c=%0d got=%b exp=%b", c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
      end
      if (locked === 1'b1 && first_lock == 0) begin
        first_lock = c;
        checks++;
        if (clkout !== 6'b111101) begin
          errors++;
          $display("FAIL pwrdwn_ch1_kept got=%b exp=%b", clkout, 6'b111101);
        end
      end
    end
    checks++;
    if (first_lock != LC) begin
      errors++;
      $display("FAIL pwrdwn_lock_cycle got=%0d exp=%0d", first_lock, LC);
    end
  endtask

  task automatic test_rst_in_apply();
    int errs = 0;
    cfg_ch = 3'd2; cfg_divide = 8'd8; cfg_high = 8'd3; cfg_phase = 8'd1;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if ({locked, cfg_ready, cfg_err, clkout} !== 9'b0) begin
      errors++;
      $display("FAIL apply_cycle got=%b exp=%b", {locked, cfg_ready, cfg_err, clkout}, 9'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_apply_model c=%0d got=%b exp=%b", c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
      end
      if (cfg_err === 1'b1) errs++;
      if (c > LC) begin
        checks++;
        if (clkout !== 6'b000000 && clkout !== 6'b111111) begin
          errors++;
          $display("FAIL rst_apply_aligned c=%0d got=%b exp=all-equal", c, clkout);
        end
      end
    end
    checks++;
    if (errs != 0) begin
      errors++;
      $display("FAIL rst_apply_no_err got=%0d exp=0", errs);
    end
  endtask

  task automatic test_valid_during_lock();
    int   rdy_cycle = 0;
    int   falls = 0;
    logic prev_l = 1'b0;
    logic acc_next = 1'b0;
    cfg_ch = 3'd3; cfg_divide = 8'd5; cfg_high = 8'd2; cfg_phase = 8'd1;
    pwrdwn = 1'b1;
    cfg_valid = 1'b1;
    @(negedge clk);
    pwrdwn = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      checks++;
      if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
        errors++;
        $display("FAIL hold_valid_model c=%0d got=%b exp=%b", c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
      end
      if (prev_l === 1'b1 && locked === 1'b0) falls++;
      prev_l = locked;
      if (acc_next && cfg_valid) begin
        cfg_valid = 1'b0;
        checks++;
        if ({locked, cfg_ready} !== 2'b00) begin
          errors++;
          $display("FAIL hold_valid_apply got=%b exp=%b", {locked, cfg_ready}, 2'b00);
        end
      end
      if (!acc_next && cfg_ready === 1'b1) begin
        acc_next = 1'b1;
        rdy_cycle = c;
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (rdy_cycle != LC) begin
      errors++;
      $display("FAIL hold_valid_ready_cycle got=%0d exp=%0d", rdy_cycle, LC);
    end
    checks++;
    if (falls != 1) begin
      errors++;
      $display("FAIL hold_valid_applies got=%0d exp=1", falls);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int   dv;
      int   idle;
      int   pd;
      logic go;
      logic acc;
      dv = $urandom_range(1, 10);
      cfg_ch     = CH_W'($urandom_range(0, 6));
      cfg_divide = CNT_W'(dv);
      cfg_high   = CNT_W'($urandom_range(0, dv));
      cfg_phase  = CNT_W'($urandom_range(0, dv));
      go  = cfg_ready;
      acc = 1'b0;
      cfg_valid = 1'b1;
      for (int c = 0; c < 40 && !acc; c++) begin
        @(negedge clk);
        checks++;
        if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
          errors++;
          $display("FAIL random_model it=%0d got=%b exp=%b", it, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
        end
        if (go) begin
          cfg_valid = 1'b0;
          acc = 1'b1;
        end else begin
          go = cfg_ready;
        end
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL random_handshake_timeout it=%0d got=no-ready exp=ready", it);
      end
      cfg_valid = 1'b0;
      idle = $urandom_range(5, 30);
      pd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      pwrdwn = (pd > 0);
      for (int c = 1; c <= idle; c++) begin
        @(negedge clk);
        checks++;
        if ({locked, cfg_ready, cfg_err, clkout} !== exp_vec()) begin
          errors++;
          $display("FAIL random_idle_model it=%0d c=%0d got=%b exp=%b", it, c, {locked, cfg_ready, cfg_err, clkout}, exp_vec());
        end
        pwrdwn = (c < pd);
      end
      pwrdwn = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_invalid();
    test_pwrdwn();
    test_rst_in_apply();
    test_valid_during_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
